// File: rtl/memory_arbiter.sv
// Arbitrates the single data-memory port between CPU load/store and video fetch.
// Optional VIDEO_PRIORITY_EN: video wins every conflict instead of round-robin.
module memory_arbiter #(
   parameter int AWIDTH       = 15,
   parameter int DWIDTH       = 32,
   parameter int READ_LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic [AWIDTH-1:0] cpu_addr,
   input  logic [DWIDTH-1:0] cpu_wdata,
   input  logic              cpu_re,
   input  logic              cpu_we,
   output logic [DWIDTH-1:0] cpu_rdata,
   output logic              cpu_done,
   output logic              cpu_err,
   input  logic              vid_req,
   input  logic [AWIDTH-1:0] vid_addr,
   output logic [DWIDTH-1:0] vid_rdata,
   output logic              vid_done,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [DWIDTH-1:0] mem_wdata,
   output logic              mem_re,
   output logic              mem_we,
   input  logic [DWIDTH-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   localparam logic       OWNER_CPU = 1'b0;
   localparam logic       OWNER_VID = 1'b1;
   localparam logic [3:0] LAT_LOAD  = 4'(READ_LATENCY);

   state_t     state_r;
   logic [3:0] cnt_r;
   logic       owner_r;
   logic       op_rd_r;
   logic       op_nop_r;
   logic       op_err_r;
`ifndef VIDEO_PRIORITY_EN
   logic       last_grant_r;
`endif

   logic cpu_valid_s;
   logic vid_valid_s;
   logic grant_s;
   logic pick_vid_s;

   // Request qualification and winner selection; a requester is ignored in its own done cycle.
   always_comb begin
      cpu_valid_s = cpu_req && !cpu_done;
      vid_valid_s = vid_req && !vid_done;
      grant_s     = cpu_valid_s || vid_valid_s;
`ifdef VIDEO_PRIORITY_EN
      pick_vid_s  = vid_valid_s;
`else
      if (cpu_valid_s && vid_valid_s) begin
         pick_vid_s = (last_grant_r == OWNER_CPU);
      end else begin
         pick_vid_s = vid_valid_s;
      end
`endif
   end

   // Access sequencer: grant in IDLE, strobe in ISSUE, count out read latency in WAIT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         cnt_r        <= 4'd0;
         owner_r      <= OWNER_CPU;
         op_rd_r      <= 1'b0;
         op_nop_r     <= 1'b0;
         op_err_r     <= 1'b0;
`ifndef VIDEO_PRIORITY_EN
         last_grant_r <= OWNER_VID;
`endif
         cpu_rdata    <= {DWIDTH{1'b0}};
         cpu_done     <= 1'b0;
         cpu_err      <= 1'b0;
         vid_rdata    <= {DWIDTH{1'b0}};
         vid_done     <= 1'b0;
         mem_addr     <= {AWIDTH{1'b0}};
         mem_wdata    <= {DWIDTH{1'b0}};
         mem_re       <= 1'b0;
         mem_we       <= 1'b0;
         busy         <= 1'b0;
      end else begin
         cpu_done <= 1'b0;
         cpu_err  <= 1'b0;
         vid_done <= 1'b0;
         mem_re   <= 1'b0;
         mem_we   <= 1'b0;
         case (state_r)
            IDLE: begin
               if (grant_s) begin
                  state_r      <= ISSUE;
                  busy         <= 1'b1;
                  owner_r      <= pick_vid_s;
`ifndef VIDEO_PRIORITY_EN
                  last_grant_r <= pick_vid_s;
`endif
                  if (pick_vid_s) begin
                     mem_addr  <= vid_addr;
                     mem_wdata <= {DWIDTH{1'b0}};
                     op_rd_r   <= 1'b1;
                     op_nop_r  <= 1'b0;
                     op_err_r  <= 1'b0;
                     mem_re    <= 1'b1;
                  end else begin
                     // re=we=1 is executed as a write but still flagged as an error.
                     mem_addr  <= cpu_addr;
                     mem_wdata <= cpu_wdata;
                     op_rd_r   <= cpu_re && !cpu_we;
                     op_nop_r  <= !cpu_re && !cpu_we;
                     op_err_r  <= (cpu_re == cpu_we);
                     mem_re    <= cpu_re && !cpu_we;
                     mem_we    <= cpu_we;
                  end
               end else begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
               end
            end
            ISSUE: begin
               if (op_rd_r) begin
                  state_r <= WAIT;
                  cnt_r   <= LAT_LOAD;
                  busy    <= 1'b1;
               end else begin
                  state_r  <= IDLE;
                  busy     <= 1'b0;
                  cpu_done <= 1'b1;
                  cpu_err  <= op_err_r;
                  if (op_nop_r) begin
                     cpu_rdata <= {DWIDTH{1'b0}};
                  end else begin
                     cpu_rdata <= cpu_rdata;
                  end
               end
            end
            WAIT: begin
               cnt_r <= cnt_r - 4'd1;
               if (cnt_r <= 4'd1) begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
                  if (owner_r == OWNER_VID) begin
                     vid_rdata <= mem_rdata;
                     vid_done  <= 1'b1;
                  end else begin
                     cpu_rdata <= mem_rdata;
                     cpu_done  <= 1'b1;
                  end
               end else begin
                  state_r <= WAIT;
                  busy    <= 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: store/load latency, error ops, reset abort, arbitration order.
`timescale 1ns/1ps
module tb_memory_arbiter;
   localparam int AW = 15;
   localparam int DW = 32;

   typedef struct {
      logic          is_vid;
      logic          err;
      logic          chk_data;
      logic [DW-1:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cpu_req, cpu_re, cpu_we, vid_req;
   logic [AW-1:0] cpu_addr, vid_addr;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata, vid_rdata, mem_wdata, mem_rdata;
   logic          cpu_done, cpu_err, vid_done, mem_re, mem_we, busy;
   logic [AW-1:0] mem_addr;

   logic          bd_we;
   logic [AW-1:0] bd_addr;
   logic [DW-1:0] bd_data;
   logic [DW-1:0] mem_model [0:(1<<AW)-1];
   logic          rd_v;
   logic [AW-1:0] rd_a;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   memory_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .READ_LATENCY(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_rdata(cpu_rdata),
      .cpu_done(cpu_done), .cpu_err(cpu_err),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_done(vid_done),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   // Memory with two-cycle read latency; data is valid only in the sampling cycle.
   always @(posedge clk) begin
      rd_v      <= mem_re;
      rd_a      <= mem_addr;
      mem_rdata <= rd_v ? mem_model[rd_a] : 32'hBAD0_BAD0;
      if (mem_we) mem_model[mem_addr] <= mem_wdata;
      if (bd_we) mem_model[bd_addr] <= bd_data;
   end

   task automatic bd_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bd_addr = a;
      bd_data = d;
      bd_we   = 1'b1;
      @(negedge clk);
      bd_we   = 1'b0;
   endtask

   task automatic push_exp(input logic v, input logic er, input logic cd, input logic [DW-1:0] d);
      exp_t e;
      e.is_vid   = v;
      e.err      = er;
      e.chk_data = cd;
      e.data     = d;
      sb_q.push_back(e);
   endtask

   task automatic test_reset();
      logic seen;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({busy, mem_we, mem_re, cpu_done, cpu_err, vid_done} !== 6'b0) begin
         n_bad++;
         $display("FAIL reset_strobes: got %b want 000000", {busy, mem_we, mem_re, cpu_done, cpu_err, vid_done});
      end
      n_cmp++;
      if (cpu_rdata !== 32'h0 || vid_rdata !== 32'h0 || mem_addr !== 15'h0 || mem_wdata !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_data: cpu_rdata=%h vid_rdata=%h mem_addr=%h mem_wdata=%h want all 0",
                  cpu_rdata, vid_rdata, mem_addr, mem_wdata);
      end
      rst_n = 1'b1;
      @(negedge clk);
      cpu_addr = 15'h0010; cpu_wdata = 32'h1234_5678; cpu_we = 1'b1; cpu_re = 1'b0; cpu_req = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (mem_we !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_pre_issue: mem_we=%b want 1", mem_we);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (mem_we !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_async_drop: mem_we=%b busy=%b want 0 0", mem_we, busy);
      end
      cpu_req = 1'b0; cpu_we = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (cpu_done === 1'b1) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_abandon: done_seen=%b busy=%b want 0 0", seen, busy);
      end
   endtask

   task automatic test_store();
      exp_t e;
      push_exp(1'b0, 1'b0, 1'b0, 32'h0);
      cpu_addr = 15'h0004; cpu_wdata = 32'h0000_0001; cpu_we = 1'b1; cpu_re = 1'b0; cpu_req = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 15'h0004 || mem_wdata !== 32'h1 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL store_issue: we=%b re=%b addr=%h wdata=%h busy=%b want 1 0 0004 00000001 1",
                  mem_we, mem_re, mem_addr, mem_wdata, busy);
      end
      @(negedge clk);
      n_cmp++;
      if (cpu_done !== 1'b1) begin
         n_bad++;
         $display("FAIL store_done: cpu_done=%b want 1", cpu_done);
      end else begin
         e = sb_q.pop_front();
         n_cmp++;
         if (cpu_err !== e.err || mem_we !== 1'b0) begin
            n_bad++;
            $display("FAIL store_err: cpu_err=%b mem_we=%b want %b 0", cpu_err, mem_we, e.err);
         end
      end
      cpu_req = 1'b0; cpu_we = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (cpu_done !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL store_idle: cpu_done=%b busy=%b want 0 0", cpu_done, busy);
      end
      sb_q.delete();
   endtask

   task automatic test_load();
      exp_t e;
      int   cyc;
      bd_write(15'h7FFF, 32'hDEAD_BEEF);
      push_exp(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
      cpu_addr = 15'h7FFF; cpu_re = 1'b1; cpu_we = 1'b0; cpu_req = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 15'h7FFF) begin
         n_bad++;
         $display("FAIL load_issue: re=%b we=%b addr=%h want 1 0 7fff", mem_re, mem_we, mem_addr);
      end
      @(negedge clk);
      n_cmp++;
      if (mem_re !== 1'b0 || cpu_done !== 1'b0 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL load_wait1: re=%b done=%b busy=%b want 0 0 1", mem_re, cpu_done, busy);
      end
      @(negedge clk);
      n_cmp++;
      if (cpu_done !== 1'b0) begin
         n_bad++;
         $display("FAIL load_wait2: cpu_done=%b want 0", cpu_done);
      end
      @(negedge clk);
      n_cmp++;
      if (cpu_done !== 1'b1) begin
         n_bad++;
         $display("FAIL load_done: cpu_done=%b want 1", cpu_done);
      end else begin
         e = sb_q.pop_front();
         n_cmp++;
         if (cpu_rdata !== e.data || cpu_err !== e.err) begin
            n_bad++;
            $display("FAIL load_data: rdata=%h err=%b want %h %b", cpu_rdata, cpu_err, e.data, e.err);
         end
      end
      cpu_req = 1'b0; cpu_re = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (cpu_done !== 1'b0 || cpu_rdata !== 32'hDEAD_BEEF) begin
         n_bad++;
         $display("FAIL load_hold: done=%b rdata=%h want 0 deadbeef", cpu_done, cpu_rdata);
      end
      // Reads back the earlier store through the memory model.
      push_exp(1'b0, 1'b0, 1'b1, 32'h0000_0001);
      cpu_addr = 15'h0004; cpu_re = 1'b1; cpu_req = 1'b1;
      cyc = 0;
      while (cpu_done !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      n_cmp++;
      if (cpu_done !== 1'b1 || cyc != 4) begin
         n_bad++;
         $display("FAIL load2_latency: done=%b cycles=%0d want 1 4", cpu_done, cyc);
      end else begin
         e = sb_q.pop_front();
         n_cmp++;
         if (cpu_rdata !== e.data) begin
            n_bad++;
            $display("FAIL load2_data: rdata=%h want %h", cpu_rdata, e.data);
         end
      end
      cpu_req = 1'b0; cpu_re = 1'b0;
      @(negedge clk);
      sb_q.delete();
   endtask

   task automatic test_error();
      exp_t e;
      push_exp(1'b0, 1'b1, 1'b1, 32'h0);
      cpu_addr = 15'h0020; cpu_re = 1'b0; cpu_we = 1'b0; cpu_req = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (mem_re !== 1'b0 || mem_we !== 1'b0) begin
         n_bad++;
         $display("FAIL nop_strobe: re=%b we=%b want 0 0", mem_re, mem_we);
      end
      @(negedge clk);
      n_cmp++;
      if (cpu_done !== 1'b1) begin
         n_bad++;
         $display("FAIL nop_done: cpu_done=%b want 1", cpu_done);
      end else begin
         e = sb_q.pop_front();
         n_cmp++;
         if (cpu_err !== e.err || cpu_rdata !== e.data) begin
            n_bad++;
            $display("FAIL nop_err: err=%b rdata=%h want %b %h", cpu_err, cpu_rdata, e.err, e.data);
         end
      end
      cpu_req = 1'b0;
      @(negedge clk);
      push_exp(1'b0, 1'b1, 1'b0, 32'h0);
      cpu_addr = 15'h0030; cpu_wdata = 32'h55AA_55AA; cpu_re = 1'b1; cpu_we = 1'b1; cpu_req = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_wdata !== 32'h55AA_55AA) begin
         n_bad++;
         $display("FAIL both_strobe: we=%b re=%b wdata=%h want 1 0 55aa55aa", mem_we, mem_re, mem_wdata);
      end
      @(negedge clk);
      n_cmp++;
      if (cpu_done !== 1'b1) begin
         n_bad++;
         $display("FAIL both_done: cpu_done=%b want 1", cpu_done);
      end else begin
         e = sb_q.pop_front();
         n_cmp++;
         if (cpu_err !== e.err || cpu_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL both_err: err=%b rdata=%h want %b 00000000", cpu_err, cpu_rdata, e.err);
         end
      end
      cpu_req = 1'b0; cpu_re = 1'b0; cpu_we = 1'b0;
      @(negedge clk);
      sb_q.delete();
   endtask

   task automatic test_conflict();
      exp_t          e;
      logic [AW-1:0] cpu_aq[$];
      logic [AW-1:0] vid_aq[$];
      logic [AW-1:0] pend_addr;
      logic [DW-1:0] got;
      logic          pend;
      int            cyc;
      bd_write(15'h0100, 32'hA1A1_0001);
      bd_write(15'h0101, 32'hA1A1_0002);
      bd_write(15'h0102, 32'hA1A1_0003);
      bd_write(15'h0200, 32'hB2B2_0001);
      bd_write(15'h0201, 32'hB2B2_0002);
      bd_write(15'h0202, 32'hB2B2_0003);
      for (int part = 0; part < 2; part++) begin
         sb_q.delete();
         cpu_aq.delete();
         vid_aq.delete();
         if (part == 0) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            cpu_aq.push_back(15'h0100); cpu_aq.push_back(15'h0101);
            vid_aq.push_back(15'h0200); vid_aq.push_back(15'h0201);
`ifdef VIDEO_PRIORITY_EN
            push_exp(1'b1, 1'b0, 1'b1, 32'hB2B2_0001);
            push_exp(1'b0, 1'b0, 1'b1, 32'hA1A1_0001);
            push_exp(1'b1, 1'b0, 1'b1, 32'hB2B2_0002);
            push_exp(1'b0, 1'b0, 1'b1, 32'hA1A1_0002);
`else
            push_exp(1'b0, 1'b0, 1'b1, 32'hA1A1_0001);
            push_exp(1'b1, 1'b0, 1'b1, 32'hB2B2_0001);
            push_exp(1'b0, 1'b0, 1'b1, 32'hA1A1_0002);
            push_exp(1'b1, 1'b0, 1'b1, 32'hB2B2_0002);
`endif
         end else begin
            // A lone CPU access first, so the next conflict must go to video.
            cpu_addr = 15'h0300; cpu_wdata = 32'h0BAD_CAFE; cpu_we = 1'b1; cpu_re = 1'b0; cpu_req = 1'b1;
            cyc = 0;
            while (cpu_done !== 1'b1 && cyc < 20) begin
               @(negedge clk);
               cyc++;
            end
            n_cmp++;
            if (cpu_done !== 1'b1) begin
               n_bad++;
               $display("FAIL lone_cpu_timeout: cpu_done=%b want 1", cpu_done);
            end
            cpu_req = 1'b0; cpu_we = 1'b0;
            @(negedge clk);
            cpu_aq.push_back(15'h0102);
            vid_aq.push_back(15'h0202);
            push_exp(1'b1, 1'b0, 1'b1, 32'hB2B2_0003);
            push_exp(1'b0, 1'b0, 1'b1, 32'hA1A1_0003);
         end
         cpu_addr = cpu_aq[0]; cpu_re = 1'b1; cpu_we = 1'b0; cpu_req = 1'b1;
         vid_addr = vid_aq[0]; vid_req = 1'b1;
         pend = 1'b0;
         pend_addr = 15'h0;
         cyc = 0;
         while (sb_q.size() > 0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (pend) begin
               pend = 1'b0;
               n_cmp++;
               if (mem_re !== 1'b1 || mem_addr !== pend_addr) begin
                  n_bad++;
                  $display("FAIL done_cycle_grant: re=%b addr=%h want 1 %h", mem_re, mem_addr, pend_addr);
               end
            end
            if (cpu_done === 1'b1 || vid_done === 1'b1) begin
               e = sb_q.pop_front();
               got = vid_done ? vid_rdata : cpu_rdata;
               n_cmp++;
               if (vid_done !== e.is_vid || cpu_done === vid_done) begin
                  n_bad++;
                  $display("FAIL grant_order: cpu_done=%b vid_done=%b want vid=%b", cpu_done, vid_done, e.is_vid);
               end
               n_cmp++;
               if (got !== e.data) begin
                  n_bad++;
                  $display("FAIL arb_rdata: got %h want %h", got, e.data);
               end
               if (cpu_done === 1'b1) begin
                  if (cpu_aq.size() > 0) void'(cpu_aq.pop_front());
                  if (cpu_aq.size() > 0) cpu_addr = cpu_aq[0];
                  else cpu_req = 1'b0;
                  if (vid_aq.size() > 0) begin
                     pend = 1'b1;
                     pend_addr = vid_aq[0];
                  end
               end else begin
                  if (vid_aq.size() > 0) void'(vid_aq.pop_front());
                  if (vid_aq.size() > 0) vid_addr = vid_aq[0];
                  else vid_req = 1'b0;
                  if (cpu_aq.size() > 0) begin
                     pend = 1'b1;
                     pend_addr = cpu_aq[0];
                  end
               end
            end
         end
         n_cmp++;
         if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL conflict_timeout: part %0d left %0d pending want 0", part, sb_q.size());
         end
         cpu_req = 1'b0; vid_req = 1'b0; cpu_re = 1'b0;
         repeat (2) @(negedge clk);
      end
      sb_q.delete();
   endtask

   initial begin
      rst_n = 1'b0;
      cpu_req = 1'b0; cpu_re = 1'b0; cpu_we = 1'b0;
      cpu_addr = 15'h0; cpu_wdata = 32'h0;
      vid_req = 1'b0; vid_addr = 15'h0;
      bd_we = 1'b0; bd_addr = 15'h0; bd_data = 32'h0;
      test_reset();
      test_store();
      test_load();
      test_error();
      test_conflict();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at 200000ns, want finished");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares the single data-memory port between the CPU load/store path and the video fetch unit.
- The CPU side is driven by the memory access mux outputs (addr, store data, read_enable, write_enable) plus a request strobe.
- The block sequences each access through a small FSM, waits out the fixed memory read latency and returns registered read data with a one-cycle done pulse.
- Conflicting requests are resolved round-robin.

Parameters:
AWIDTH, 15, memory word-address width
DWIDTH, 32, data width
READ_LATENCY, 2, cycles from mem_re assertion to mem_rdata valid (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cpu_req  input  1  CPU access request, held until cpu_done
cpu_addr  input  AWIDTH  CPU word address
cpu_wdata  input  DWIDTH  CPU store data
cpu_re  input  1  CPU load (read_enable from mux)
cpu_we  input  1  CPU store (write_enable from mux)
cpu_rdata  output  DWIDTH  registered load data, valid while cpu_done=1
cpu_done  output  1  one-cycle completion pulse
cpu_err  output  1  one-cycle pulse: request with re=we=1 or re=we=0
vid_req  input  1  video read request, held until vid_done
vid_addr  input  AWIDTH  video word address
vid_rdata  output  DWIDTH  registered read data, valid while vid_done=1
vid_done  output  1  one-cycle completion pulse
mem_addr  output  AWIDTH  memory address
mem_wdata  output  DWIDTH  memory write data
mem_re  output  1  memory read strobe
mem_we  output  1  memory write strobe
mem_rdata  input  DWIDTH  memory read data
busy  output  1  high whenever FSM not in IDLE

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FSM=IDLE, latency counter 0, last_grant=VID (CPU wins the first conflict). Strobes drop immediately.
- Reset mid-access: the transaction is abandoned and no done pulse is produced. Requesters re-request after reset.
- All outputs are registered; none is driven to z.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Valid requests are cpu_req && !cpu_done, and vid_req && !vid_done. A request is ignored in its own done cycle.
  - With one valid request, grant it.
  - With both valid, grant the requester opposite last_grant.
  - On grant: latch address, wdata and op into internal registers, update last_grant, go to ISSUE.
- CPU op decode:
  - we=1, re=0: write.
  - re=1, we=0: read.
  - re=we=1: treated as write, cpu_err pulses with cpu_done.
  - re=we=0: no memory strobe. In the ISSUE cycle the FSM returns to IDLE; next cycle cpu_done=1 and cpu_err=1 together, with cpu_rdata=0.
- ISSUE (1 cycle):
  - mem_addr and mem_wdata come from the latched registers.
  - Write: mem_we=1. Next cycle the done pulse is high and the FSM is back in IDLE.
  - Read: mem_re=1, counter loads READ_LATENCY, go to WAIT.
- WAIT:
  - Counter decrements each cycle. mem_re=0, mem_we=0.
  - When the counter reaches 1, mem_rdata is captured into the winner's rdata register, the done pulse is set for the next cycle and the FSM goes to IDLE.
- Latency, with the request accepted in IDLE at cycle N:
  - Write: mem_we at N+1, done at N+2.
  - Read: mem_re at N+1, mem_rdata sampled at N+1+READ_LATENCY, done and rdata at N+2+READ_LATENCY.
- The earliest next grant is in the done cycle, for the other requester. Video requests are always reads; the video port cannot write.
- cpu_rdata and vid_rdata hold their value until the next capture for the same requester. Only the done pulse qualifies them.
- A request withdrawn before done is not supported: the access completes and the done pulse still fires.

Optional Feature:
- VIDEO_PRIORITY_EN defined: on conflict, video always wins; last_grant is unused.
  - The CPU is served only when vid_req is low or in vid_done cycles, so a back-to-back video stream is still interleaved with CPU accesses.
- VIDEO_PRIORITY_EN undefined: round-robin as above.

Test Plan:
- Reset: rst_n=0 during ISSUE of a write to 0x0010 -> mem_we falls to 0 immediately; no cpu_done; busy=0 after release.
- CPU store: cpu_req=1, we=1, addr=0x0004, wdata=0x00000001 at N -> mem_we=1, mem_addr=0x0004, mem_wdata=1 at N+1; cpu_done=1 at N+2.
- CPU load: memory model returns 0xDEADBEEF 2 cycles after mem_re; request addr=0x7FFF at N -> mem_re at N+1; cpu_done=1 and cpu_rdata=0xDEADBEEF at N+4.
- Conflict: cpu_req and vid_req both rise at N after reset -> CPU granted first. Video is granted in the cpu_done cycle. A second simultaneous pair is served video-first only if the CPU was served last; grant order alternates CPU/VID over 4 accesses.
- Error op: cpu_req with re=we=0 -> no mem strobe; cpu_done=1 and cpu_err=1 at N+2. With re=we=1 -> mem_we=1 at N+1; cpu_err=1 with cpu_done.
- VIDEO_PRIORITY_EN defined: simultaneous requests twice -> video granted both times; CPU is served in between, during the vid_done cycle.
